fetch_unit: RTL and testbench

Instruction fetch stage feeding the decode stage: owns the PC and issues blocking reads to instruction memory. It buffers returned words in a 2-entry queue and presents `ID_Instruction`/`ID_PC`/`ID_valid` to the control ROM and register-file read logic. It absorbs decode stalls and applies branch/jump redirects resolved in MEM, discarding wrong-path fetches.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one blocking imem read at a time and
// buffers returned words in a 2-entry queue for decode. Optional macro: FETCH_BYPASS_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_stall,
   output logic [31:0] ID_Instruction,
   output logic [31:0] ID_PC,
   output logic        ID_valid
);

   typedef enum logic [1:0] {START, FETCH, HOLD, DISCARD} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] req_addr, req_addr_next;
   logic [1:0]  count, count_next;
   logic [31:0] q_pc [2];
   logic [31:0] q_instr [2];
   logic [31:0] q_pc_next [2];
   logic [31:0] q_instr_next [2];
   logic        fetch_resp, bypass, enq, deq, wr_idx;

   assign fetch_resp = (state == FETCH) && imem_resp;
`ifdef FETCH_BYPASS_EN
   assign bypass = fetch_resp && !redirect && (count == 2'd0);
`else
   assign bypass = 1'b0;
`endif
   // A bypassed word that decode takes this cycle never enters the queue
   assign deq = (count != 2'd0) && !id_stall && !redirect;
   assign enq = fetch_resp && !redirect && !(bypass && !id_stall);

   assign imem_read    = (state == FETCH) || (state == DISCARD);
   assign imem_address = req_addr;

   always_comb begin
      ID_valid       = 1'b0;
      ID_PC          = 32'h0;
      ID_Instruction = 32'h0;
      if (bypass) begin
         ID_valid       = 1'b1;
         ID_PC          = pc;
         ID_Instruction = imem_rdata;
      end else if (count != 2'd0) begin
         ID_valid       = 1'b1;
         ID_PC          = q_pc[0];
         ID_Instruction = q_instr[0];
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      count_next = redirect ? 2'd0 : (count + {1'b0, enq} - {1'b0, deq});
      if (redirect) begin
         pc_next = redirect_pc;
         if (((state == FETCH) || (state == DISCARD)) && !imem_resp)
            state_next = DISCARD;
         else
            state_next = FETCH;
      end else begin
         case (state)
            START:   state_next = FETCH;
            FETCH:   if (imem_resp) begin
                        pc_next    = pc + 32'd4;
                        state_next = (count_next == 2'd2) ? HOLD : FETCH;
                     end
            HOLD:    if (count_next <= 2'd1) state_next = FETCH;
            DISCARD: if (imem_resp) state_next = FETCH;
            default: state_next = START;
         endcase
      end
      // The in-flight address must survive a redirect until its stale response returns
      req_addr_next = (state_next == DISCARD) ? req_addr : pc_next;
   end

   always_comb begin
      q_pc_next    = q_pc;
      q_instr_next = q_instr;
      wr_idx       = (count - {1'b0, deq}) != 2'd0;
      if (deq) begin
         q_pc_next[0]    = q_pc[1];
         q_instr_next[0] = q_instr[1];
      end
      if (enq) begin
         q_pc_next[wr_idx]    = pc;
         q_instr_next[wr_idx] = imem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= START;
         pc         <= RESET_PC;
         req_addr   <= RESET_PC;
         count      <= 2'd0;
         q_pc[0]    <= 32'h0;
         q_pc[1]    <= 32'h0;
         q_instr[0] <= 32'h0;
         q_instr[1] <= 32'h0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         req_addr   <= req_addr_next;
         count      <= count_next;
         q_pc[0]    <= q_pc_next[0];
         q_pc[1]    <= q_pc_next[1];
         q_instr[0] <= q_instr_next[0];
         q_instr[1] <= q_instr_next[1];
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed protocol scenarios followed by random
// stall/redirect/response traffic, checked against a transaction-level queue model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0060;
`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_read;
   logic [31:0] imem_address;
   logic        imem_resp = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_stall = 1'b0;
   logic [31:0] ID_Instruction;
   logic [31:0] ID_PC;
   logic        ID_valid;

   int checks = 0;
   int errors = 0;

   fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .id_stall(id_stall),
      .ID_Instruction(ID_Instruction), .ID_PC(ID_PC), .ID_valid(ID_valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   // Model: words delivered in program order, one open read, wrong-path reads marked stale
   entry_t      mq[$];
   logic [31:0] m_next_pc;
   logic [31:0] m_inflight;
   bit          m_out;
   bit          m_stale;

   logic        s_read, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      m_next_pc  = RESET_PC;
      m_inflight = RESET_PC;
      m_out      = 1'b0;
      m_stale    = 1'b0;
   endtask

   task automatic modelOpenRead();
      if (!m_out && mq.size() <= 1) begin
         m_out      = 1'b1;
         m_inflight = m_next_pc;
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs, then advance the model
   task automatic applyStimulus(input bit stall, input bit redir,
                                input logic [31:0] rpc, input bit resp_ok);
      bit          byp, e_valid, consume;
      logic [31:0] e_pc, e_instr;
      entry_t      e;
      @(negedge clk);
      id_stall    = stall;
      redirect    = redir;
      redirect_pc = rpc;
      imem_resp   = resp_ok && imem_read;
      imem_rdata  = imem_resp ? mem_word(imem_address) : $urandom();
      #1;
      s_read  = imem_read;
      s_addr  = imem_address;
      s_valid = ID_valid;
      s_pc    = ID_PC;
      s_instr = ID_Instruction;

      byp     = BYP && m_out && !m_stale && imem_resp && !redir && (mq.size() == 0);
      e_valid = (mq.size() != 0) || byp;
      e_pc    = 32'h0;
      e_instr = 32'h0;
      if (byp) begin
         e_pc    = m_inflight;
         e_instr = mem_word(m_inflight);
      end else if (mq.size() != 0) begin
         e_pc    = mq[0].pc;
         e_instr = mq[0].instr;
      end
      checkOutput("imem_read", imem_read, m_out);
      checkOutput("imem_address", imem_address, m_out ? m_inflight : m_next_pc);
      checkOutput("ID_valid", ID_valid, e_valid);
      checkOutput("ID_PC", ID_PC, e_pc);
      checkOutput("ID_Instruction", ID_Instruction, e_instr);
      if (mq.size() == 2) checkOutput("no_enq_when_full", imem_read, 0);

      consume = e_valid && !stall && !redir;
      if (redir) begin
         mq.delete();
         m_next_pc = rpc;
         if (m_out && !imem_resp) m_stale = 1'b1;
         else begin
            m_out   = 1'b0;
            m_stale = 1'b0;
         end
      end else begin
         if (consume && !byp) void'(mq.pop_front());
         if (m_out && imem_resp) begin
            m_out = 1'b0;
            if (m_stale) m_stale = 1'b0;
            else begin
               if (!(byp && !stall)) begin
                  e.pc    = m_inflight;
                  e.instr = mem_word(m_inflight);
                  mq.push_back(e);
               end
               m_next_pc = m_inflight + 32'd4;
            end
         end
      end
      modelOpenRead();
   endtask

   // Asynchronous reset mid-cycle, optionally with a stray response while in START
   task automatic doReset(input bit late_resp);
      @(negedge clk);
      #2;
      rst_n      = 1'b0;
      redirect   = 1'b0;
      id_stall   = 1'b0;
      imem_resp  = late_resp;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      modelReset();
      checkOutput("rst_imem_read", imem_read, 0);
      checkOutput("rst_imem_address", imem_address, RESET_PC);
      checkOutput("rst_ID_valid", ID_valid, 0);
      checkOutput("rst_ID_PC", ID_PC, 0);
      checkOutput("rst_ID_Instruction", ID_Instruction, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("start_imem_read", imem_read, 0);
      checkOutput("start_ID_valid", ID_valid, 0);
      modelOpenRead();
   endtask

   initial begin
      logic [31:0] exp_seq;
      logic [31:0] rpc;
      $display("[TB] fetch_unit bench starting");

      // Memory answers every second cycle, decode never stalls
      doReset(1'b0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("first_read", s_read, 1);
      checkOutput("first_addr", s_addr, RESET_PC);
      exp_seq = RESET_PC;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(0, 0, 0, (i % 2) == 0);
         if (s_valid) begin
            checkOutput("seq_pc", s_pc, exp_seq);
            exp_seq = exp_seq + 32'd4;
         end
      end

      // Long stall fills the queue, then drains in order
      doReset(1'b0);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1);
      checkOutput("hold_read", s_read, 0);
      checkOutput("hold_head_pc", s_pc, 32'h60);
      applyStimulus(0, 0, 0, 0);
      checkOutput("drain0_pc", s_pc, 32'h60);
      applyStimulus(0, 0, 0, 0);
      checkOutput("drain1_pc", s_pc, 32'h64);
      checkOutput("resume_addr", s_addr, 32'h68);
      checkOutput("resume_read", s_read, 1);

      // Redirect while a read is in flight
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 1, 32'h200, 0);
      checkOutput("redir_inflight_addr", s_addr, 32'h68);
      applyStimulus(0, 0, 0, 0);
      checkOutput("discard_addr", s_addr, 32'h68);
      checkOutput("discard_valid", s_valid, 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("stale_resp_addr", s_addr, 32'h68);
      applyStimulus(1, 0, 0, 1);
      checkOutput("target_addr", s_addr, 32'h200);
      checkOutput("target_valid", s_valid, BYP);
      applyStimulus(1, 0, 0, 0);
      checkOutput("target_pc", s_pc, 32'h200);
      checkOutput("target_instr", s_instr, mem_word(32'h200));

      // Redirect coincident with a response under stall, then redirect from HOLD
      applyStimulus(1, 1, 32'h300, 1);
      applyStimulus(1, 0, 0, 1);
      checkOutput("coinc_valid", s_valid, BYP);
      checkOutput("coinc_addr", s_addr, 32'h300);
      checkOutput("coinc_read", s_read, 1);
      applyStimulus(1, 0, 0, 1);
      applyStimulus(1, 1, 32'h400, 0);
      checkOutput("hold2_read", s_read, 0);
      checkOutput("hold2_pc", s_pc, 32'h300);
      applyStimulus(0, 0, 0, 0);
      checkOutput("hold_redir_valid", s_valid, 0);
      checkOutput("hold_redir_addr", s_addr, 32'h400);

      // PC wrap at the top of the address space
      applyStimulus(0, 1, 32'hFFFF_FFFC, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 0, 0, 1);
      checkOutput("wrap_fetch_addr", s_addr, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0);
      checkOutput("wrap_next_addr", s_addr, 32'h0);
      checkOutput("wrap_pc", s_pc, 32'hFFFF_FFFC);

      // Reset pulsed during an open read, stray response while in START
      doReset(1'b1);
      applyStimulus(0, 0, 0, 1);
      checkOutput("restart_read", s_read, 1);
      checkOutput("restart_addr", s_addr, RESET_PC);
      checkOutput("restart_valid_same", s_valid, BYP);
      applyStimulus(0, 0, 0, 0);
      checkOutput("restart_valid_next", s_valid, !BYP);

      // Random traffic
      for (int i = 0; i < 1500; i++) begin
         if (i % 500 == 250) doReset(1'($urandom_range(0, 1)));
         rpc = $urandom();
         rpc[1:0] = 2'b00;
         if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
         applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, rpc,
                       $urandom_range(0, 2) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
